// File: rtl/sd_pkg.sv
// Shared encodings for the SD command scheduler: response kinds, completion
// status, FSM states and the CMD55 / APP_CMD constants.
package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_R48  = 2'd1,
        RESP_R136 = 2'd2
    } sd_resp_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_CRC_ERR  = 2'd1,
        ST_TIMEOUT  = 2'd2,
        ST_APP_FAIL = 2'd3
    } sd_status_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_SEND_APP,
        S_WAIT_APP_TX,
        S_WAIT_APP_RESP,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_RESP,
        S_DONE
    } sd_state_e;

    localparam logic [5:0] CMD55_IDX   = 6'd55;
    localparam int         APP_CMD_BIT = 13;

    function automatic logic [37:0] sd_frame(input logic [5:0] idx, input logic [31:0] arg);
        return {idx, arg};
    endfunction

endpackage

// File: rtl/sd_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that did not win last
// time gets the bus. The remembered grant only moves when update_i is high.
module sd_rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       winner_o,
    output logic       last_grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        winner_o = (req_i == 2'b11) ? ~last_q : req_i[1];
        last_d   = update_i ? winner_o : last_q;
    end

    // Starts at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant_o = last_q;

endmodule

// File: rtl/sd_cmd_scheduler.sv
// Shares the SD CMD serializer/receiver between the init FSM and the UART
// bridge: round-robin grant, CMD55 prefixing, response timeout and CRC retry.
module sd_cmd_scheduler
    import sd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int MAX_RETRY    = 2,
    parameter int TO_W         = 7
) (
    input  logic         ex_clk,
    input  logic         reset,
    input  logic         software_reset,
    input  logic [1:0]   req,
    input  logic [1:0]   is_acmd,
    input  logic [5:0]   cmd_idx0,
    input  logic [5:0]   cmd_idx1,
    input  logic [31:0]  cmd_arg0,
    input  logic [31:0]  cmd_arg1,
    input  logic [1:0]   resp_type0,
    input  logic [1:0]   resp_type1,
    input  logic [15:0]  rca,
    input  logic         send_done,
    input  logic         sd_receive_finished,
    input  logic         crc_response_err,
    input  logic [127:0] response,
    output logic         send_en,
    output logic [37:0]  send_cmd_content,
    output logic         receive_en,
    output logic         R2_response,
    output logic [1:0]   ack,
    output logic [1:0]   status,
    output logic [127:0] resp_data
);

    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    sd_state_e        state_q, state_d;
    logic [RT_W-1:0]  retry_q, retry_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    sd_status_e       status_q, status_d;
    logic [127:0]     resp_data_q, resp_data_d;

    logic [5:0]       idx_q;
    logic [31:0]      arg_q;
    sd_resp_e         rtype_q;
    logic             acmd_q;

    logic             arb_upd;
    logic             winner;
    logic             last_grant;
    logic             armed;
    logic             to_hit;

    sd_rr_arbiter2 u_arb (
        .clk_i        (ex_clk),
        .rst_i        (reset),
        .req_i        (req),
        .update_i     (arb_upd),
        .winner_o     (winner),
        .last_grant_o (last_grant)
    );

    assign armed  = (state_q == S_WAIT_APP_RESP) || (state_q == S_WAIT_RESP);
    assign to_hit = (to_cnt_q == TO_W'(RESP_TIMEOUT - 1));

    always_comb begin
        state_d          = state_q;
        retry_d          = retry_q;
        to_cnt_d         = to_cnt_q;
        status_d         = status_q;
        resp_data_d      = resp_data_q;
        arb_upd          = 1'b0;
        send_en          = 1'b0;
        send_cmd_content = '0;
        receive_en       = 1'b0;
        R2_response      = 1'b0;
        ack              = 2'b00;
        status           = ST_OK;

        if (armed) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (armed && sd_receive_finished) begin
            resp_data_d = response;
        end

        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                if (|req) begin
                    arb_upd = 1'b1;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                state_d = acmd_q ? S_SEND_APP : S_SEND;
            end
            S_SEND_APP: begin
                send_en          = 1'b1;
                send_cmd_content = sd_frame(CMD55_IDX, {rca, 16'h0000});
                state_d          = S_WAIT_APP_TX;
            end
            S_WAIT_APP_TX: begin
                if (send_done) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_APP_RESP;
                end
            end
            S_WAIT_APP_RESP: begin
                receive_en = 1'b1;
                // A finished response takes priority over a same-cycle timeout.
                if (sd_receive_finished) begin
                    if (!crc_response_err && response[APP_CMD_BIT]) begin
                        state_d = S_SEND;
                    end else begin
                        status_d = ST_APP_FAIL;
                        state_d  = S_DONE;
                    end
                end else if (to_hit) begin
                    status_d = ST_APP_FAIL;
                    state_d  = S_DONE;
                end
            end
            S_SEND: begin
                send_en          = 1'b1;
                send_cmd_content = sd_frame(idx_q, arg_q);
                state_d          = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (send_done) begin
                    if (rtype_q == RESP_NONE) begin
                        status_d = ST_OK;
                        state_d  = S_DONE;
                    end else begin
                        to_cnt_d = '0;
                        state_d  = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                receive_en  = 1'b1;
                R2_response = (rtype_q == RESP_R136);
                if (sd_receive_finished) begin
                    if (!crc_response_err) begin
                        status_d = ST_OK;
                        state_d  = S_DONE;
                    end else if (retry_q < RT_W'(MAX_RETRY)) begin
                        // Back through ARB so an ACMD gets its CMD55 again.
                        retry_d = retry_q + RT_W'(1);
                        state_d = S_ARB;
                    end else begin
                        status_d = ST_CRC_ERR;
                        state_d  = S_DONE;
                    end
                end else if (to_hit) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                ack     = last_grant ? 2'b10 : 2'b01;
                status  = status_q;
                retry_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (software_reset) begin
            state_d  = S_IDLE;
            retry_d  = '0;
            to_cnt_d = '0;
            status_d = ST_OK;
            arb_upd  = 1'b0;
            send_en  = 1'b0;
            ack      = 2'b00;
            status   = ST_OK;
        end
    end

    always_ff @(posedge ex_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            retry_q     <= '0;
            to_cnt_q    <= '0;
            status_q    <= ST_OK;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            to_cnt_q    <= to_cnt_d;
            status_q    <= status_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Command fields are only consumed after being latched at grant time.
    always_ff @(posedge ex_clk) begin
        if (arb_upd) begin
            idx_q   <= winner ? cmd_idx1 : cmd_idx0;
            arg_q   <= winner ? cmd_arg1 : cmd_arg0;
            rtype_q <= sd_resp_e'(winner ? resp_type1 : resp_type0);
            acmd_q  <= is_acmd[winner];
        end
    end

    assign resp_data = resp_data_q;

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
// Randomized bench for sd_cmd_scheduler: a transaction-level model predicts
// frames, status and captured response from a planned list of card outcomes.
module tb_sd_cmd_scheduler;

    localparam int RESP_TIMEOUT = 64;
    localparam int MAX_RETRY    = 2;
    localparam int TO_W         = 7;

    typedef struct packed {
        logic         to;
        logic         crc;
        logic         b13;
        logic [6:0]   dly;
        logic [127:0] rsp;
    } outc_t;

    logic         ex_clk = 1'b0;
    logic         reset = 1'b1;
    logic         software_reset = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [1:0]   is_acmd = 2'b00;
    logic [5:0]   cmd_idx0 = '0, cmd_idx1 = '0;
    logic [31:0]  cmd_arg0 = '0, cmd_arg1 = '0;
    logic [1:0]   resp_type0 = '0, resp_type1 = '0;
    logic [15:0]  rca = '0;
    logic         send_done = 1'b0;
    logic         sd_receive_finished = 1'b0;
    logic         crc_response_err = 1'b0;
    logic [127:0] response = '0;
    logic         send_en;
    logic [37:0]  send_cmd_content;
    logic         receive_en;
    logic         R2_response;
    logic [1:0]   ack;
    logic [1:0]   status;
    logic [127:0] resp_data;

    sd_cmd_scheduler #(
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY),
        .TO_W         (TO_W)
    ) dut (
        .ex_clk              (ex_clk),
        .reset               (reset),
        .software_reset      (software_reset),
        .req                 (req),
        .is_acmd             (is_acmd),
        .cmd_idx0            (cmd_idx0),
        .cmd_idx1            (cmd_idx1),
        .cmd_arg0            (cmd_arg0),
        .cmd_arg1            (cmd_arg1),
        .resp_type0          (resp_type0),
        .resp_type1          (resp_type1),
        .rca                 (rca),
        .send_done           (send_done),
        .sd_receive_finished (sd_receive_finished),
        .crc_response_err    (crc_response_err),
        .response            (response),
        .send_en             (send_en),
        .send_cmd_content    (send_cmd_content),
        .receive_en          (receive_en),
        .R2_response         (R2_response),
        .ack                 (ack),
        .status              (status),
        .resp_data           (resp_data)
    );

    always #5 ex_clk = ~ex_clk;

    int cyc = 0;
    always @(posedge ex_clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Card/serializer emulation state
    outc_t       plan[$];
    logic [37:0] obs_frames[$];
    logic [37:0] exp_frames[$];
    logic [37:0] last_frame = '0;
    outc_t       cur;
    int          rsp_phase = 0;
    int          tx_wait = 0;
    int          rcnt = 0;
    int          first_send_cyc = -1;
    logic [1:0]  cur_rt = '0;
    bit          sr_abort = 1'b0;

    // Reference model state
    bit           last_g = 1'b1;
    logic [127:0] exp_resp = '0;

    function automatic outc_t mk_outc(input logic to, input logic crc, input logic b13,
                                      input logic [6:0] dly, input logic [127:0] rsp);
        outc_t o;
        o.to  = to;
        o.crc = crc;
        o.b13 = b13;
        o.dly = dly;
        o.rsp = rsp;
        o.rsp[13] = b13;
        return o;
    endfunction

    function automatic outc_t rand_outc();
        int r;
        logic [6:0] d;
        r = $urandom_range(0, 99);
        case ($urandom_range(0, 3))
            0:       d = 7'd0;
            1:       d = 7'd63;
            default: d = 7'($urandom_range(1, 20));
        endcase
        return mk_outc(r < 12, (r >= 12) && (r < 40), $urandom_range(0, 9) != 0, d,
                       {$urandom, $urandom, $urandom, $urandom});
    endfunction

    // One clock of the emulated serializer and receiver, run after each edge.
    task automatic rsp_step();
        send_done           = 1'b0;
        sd_receive_finished = 1'b0;
        crc_response_err    = 1'b0;
        if (rsp_phase == 3 && !receive_en) begin
            if (cur.to && !sr_abort) check("to_window", 128'(rcnt), 128'(RESP_TIMEOUT));
            rsp_phase = 0;
        end
        if (rsp_phase == 2) begin
            if (receive_en) begin
                check("r2_level", 128'(R2_response),
                      128'((last_frame[37:32] != 6'd55) && (cur_rt == 2'd2)));
                if (plan.size() > 0) cur = plan.pop_front();
                else cur = mk_outc(1'b0, 1'b0, 1'b1, 7'd0, '0);
                rcnt = 0;
                rsp_phase = 3;
            end else begin
                rsp_phase = 0;
            end
        end
        if (rsp_phase == 0) begin
            if (send_en) begin
                if (obs_frames.size() == 0) first_send_cyc = cyc;
                obs_frames.push_back(send_cmd_content);
                last_frame = send_cmd_content;
                tx_wait = $urandom_range(0, 3);
                rsp_phase = 1;
            end
        end else if (rsp_phase == 1) begin
            if (tx_wait == 0) begin
                send_done = 1'b1;
                rsp_phase = 2;
            end else begin
                tx_wait--;
            end
        end
        if (rsp_phase == 3) begin
            if (!cur.to && rcnt == int'(cur.dly)) begin
                sd_receive_finished = 1'b1;
                crc_response_err    = cur.crc;
                response            = cur.rsp;
                rsp_phase           = 0;
            end else begin
                rcnt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge ex_clk);
        #1;
        rsp_step();
    endtask

    // Walks the command rules over the planned outcomes, attempt by attempt.
    task automatic predict(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input bit acmd, input logic [15:0] rc, output logic [1:0] st);
        outc_t q[$];
        outc_t o;
        q = plan;
        exp_frames.delete();
        st = 2'd0;
        for (int t = 0; t <= MAX_RETRY; t++) begin
            if (acmd) begin
                exp_frames.push_back({6'd55, rc, 16'h0000});
                o = q.pop_front();
                if (!o.to) exp_resp = o.rsp;
                if (o.to || o.crc || !o.b13) begin
                    st = 2'd3;
                    return;
                end
            end
            exp_frames.push_back({idx, arg});
            if (rt == 2'd0) begin
                st = 2'd0;
                return;
            end
            o = q.pop_front();
            if (o.to) begin
                st = 2'd2;
                return;
            end
            exp_resp = o.rsp;
            if (!o.crc) begin
                st = 2'd0;
                return;
            end
            if (t == MAX_RETRY) begin
                st = 2'd1;
                return;
            end
        end
    endtask

    task automatic run_txn(input string nm, input logic [1:0] rq,
                           input logic [5:0] i0, input logic [5:0] i1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [1:0] t0, input logic [1:0] t1,
                           input logic [1:0] ac, input logic [15:0] rc);
        bit w;
        logic [1:0] st;
        int n;
        int req_cyc;
        w = (rq == 2'b11) ? ~last_g : rq[1];
        last_g = w;
        predict(w ? i1 : i0, w ? a1 : a0, w ? t1 : t0, ac[w], rc, st);
        obs_frames.delete();
        first_send_cyc = -1;
        cur_rt = w ? t1 : t0;
        cmd_idx0 = i0; cmd_idx1 = i1;
        cmd_arg0 = a0; cmd_arg1 = a1;
        resp_type0 = t0; resp_type1 = t1;
        is_acmd = ac;
        rca = rc;
        req = rq;
        req_cyc = cyc;
        n = 0;
        while (ack == 2'b00 && n < 3000) begin
            tick();
            n++;
        end
        if (ack == 2'b00) begin
            check({nm, "_ack_wait"}, 128'(0), 128'(1));
            reset = 1'b1;
            tick();
            reset = 1'b0;
            last_g = 1'b1;
            exp_resp = '0;
            rsp_phase = 0;
        end else begin
            check({nm, "_ack"}, 128'(ack), 128'(w ? 2'b10 : 2'b01));
            check({nm, "_status"}, 128'(status), 128'(st));
            check({nm, "_resp_data"}, resp_data, exp_resp);
            check({nm, "_rx_off"}, 128'(receive_en), 128'(0));
            check({nm, "_latency"}, 128'(first_send_cyc - req_cyc), 128'(2));
            check({nm, "_n_frames"}, 128'(obs_frames.size()), 128'(exp_frames.size()));
            for (int i = 0; i < obs_frames.size() && i < exp_frames.size(); i++)
                check({nm, "_frame"}, 128'(obs_frames[i]), 128'(exp_frames[i]));
        end
        req = 2'b00;
        tick();
        check({nm, "_ack_pulse"}, 128'(ack), 128'(0));
        plan.delete();
    endtask

    initial begin
        logic [5:0]  ri0, ri1;
        logic [1:0]  acc;
        bit          w;
        int          n;

        repeat (3) tick();
        check("rst_ctrl", 128'({send_en, receive_en, R2_response, ack, status}), 128'(0));
        check("rst_content", 128'(send_cmd_content), 128'(0));
        check("rst_resp", resp_data, 128'(0));
        reset = 1'b0;
        tick();

        plan.push_back(mk_outc(1'b0, 1'b0, 1'b0, 7'd10, {4{32'hA5C3_0F1E}}));
        run_txn("cmd2_r136", 2'b01, 6'd2, 6'd0, 32'h0, 32'h0, 2'd2, 2'd0, 2'b00, 16'h0);

        plan.push_back(mk_outc(1'b0, 1'b0, 1'b1, 7'd3, 128'h0000_0120));
        plan.push_back(mk_outc(1'b0, 1'b0, 1'b0, 7'd5, 128'h00FF_8000_C0DE));
        run_txn("acmd41", 2'b10, 6'd0, 6'd41, 32'h0, 32'h40FF_8000, 2'd0, 2'd1, 2'b10, 16'h1234);

        plan.push_back(mk_outc(1'b0, 1'b0, 1'b0, 7'd4, 128'h0000_0900));
        run_txn("app_fail", 2'b01, 6'd6, 6'd0, 32'h2, 32'h0, 2'd1, 2'd0, 2'b01, 16'h4321);

        repeat (3) plan.push_back(mk_outc(1'b0, 1'b1, 1'b1, 7'd2, {4{$urandom}}));
        run_txn("crc_retry", 2'b10, 6'd0, 6'd17, 32'h0, 32'h200, 2'd0, 2'd1, 2'b00, 16'h0);

        plan.push_back(mk_outc(1'b1, 1'b0, 1'b1, 7'd0, '0));
        run_txn("timeout", 2'b10, 6'd0, 6'd13, 32'h0, 32'h1, 2'd0, 2'd1, 2'b00, 16'h0);

        plan.push_back(mk_outc(1'b0, 1'b0, 1'b1, 7'd63, {4{32'h1357_9BDF}}));
        run_txn("rr_first", 2'b11, 6'd9, 6'd10, 32'h11, 32'h22, 2'd1, 2'd2, 2'b00, 16'h0);
        plan.push_back(mk_outc(1'b0, 1'b0, 1'b1, 7'd1, {4{32'h2468_ACE0}}));
        run_txn("rr_second", 2'b11, 6'd9, 6'd10, 32'h11, 32'h22, 2'd1, 2'd2, 2'b00, 16'h0);

        // Abort a transaction in WAIT_RESP, then confirm the grant rotates.
        plan.push_back(mk_outc(1'b1, 1'b0, 1'b1, 7'd0, '0));
        w = ~last_g;
        last_g = w;
        cmd_idx0 = 6'd7; cmd_idx1 = 6'd8;
        resp_type0 = 2'd1; resp_type1 = 2'd1;
        is_acmd = 2'b00;
        cur_rt = 2'd1;
        req = 2'b11;
        n = 0;
        while (!receive_en && n < 100) begin
            tick();
            n++;
        end
        check("sr_reach_wait", 128'(receive_en), 128'(1));
        tick();
        tick();
        software_reset = 1'b1;
        req = 2'b00;
        sr_abort = 1'b1;
        tick();
        software_reset = 1'b0;
        check("sr_outputs_idle", 128'({receive_en, R2_response, send_en}), 128'(0));
        acc = 2'b00;
        for (int i = 0; i < 6; i++) begin
            acc = acc | ack;
            tick();
        end
        check("sr_no_ack", 128'(acc), 128'(0));
        sr_abort = 1'b0;
        plan.delete();
        plan.push_back(mk_outc(1'b0, 1'b0, 1'b1, 7'd2, {4{32'hFEED_0001}}));
        run_txn("rr_after_sr", 2'b11, 6'd7, 6'd8, 32'h5, 32'h6, 2'd1, 2'd1, 2'b00, 16'h0);

        for (int k = 0; k < 40; k++) begin
            do ri0 = 6'($urandom); while (ri0 == 6'd55);
            do ri1 = 6'($urandom); while (ri1 == 6'd55);
            for (int j = 0; j < 8; j++) plan.push_back(rand_outc());
            run_txn("rand", 2'($urandom_range(1, 3)), ri0, ri1, $urandom, $urandom,
                    2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                    2'($urandom_range(0, 3)), 16'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
